// File: rtl/return_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : return_collector_if
//  Purpose  : Bundle of the allocation, completion and in-order return ports
//             of return_collector.
//  Modports : master - requester / completer / consumer side (drives requests,
//                      completions and ret_ready)
//             slave  - return_collector side
//  Signals  : alloc_valid/alloc_is_read/alloc_ready/alloc_tag   tag allocation
//             cpl_valid/cpl_tag/cpl_data/cpl_error              completions
//             ret_valid/ret_is_read/ret_data/ret_ready          ordered returns
//             outstanding                                       occupancy
//  Revision : 1.0 - initial release
// ============================================================================
interface return_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                  alloc_valid;
  logic                  alloc_is_read;
  logic                  alloc_ready;
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  cpl_valid;
  logic [TAG_WIDTH-1:0]  cpl_tag;
  logic [DATA_WIDTH-1:0] cpl_data;
  logic                  cpl_error;
  logic                  ret_valid;
  logic                  ret_is_read;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  ret_ready;
  logic [TAG_WIDTH:0]    outstanding;

  modport master (
    output alloc_valid, alloc_is_read, cpl_valid, cpl_tag, cpl_data, ret_ready,
    input  alloc_ready, alloc_tag, cpl_error, ret_valid, ret_is_read, ret_data,
           outstanding
  );

  modport slave (
    input  alloc_valid, alloc_is_read, cpl_valid, cpl_tag, cpl_data, ret_ready,
    output alloc_ready, alloc_tag, cpl_error, ret_valid, ret_is_read, ret_data,
           outstanding
  );
endinterface
`default_nettype wire

// File: rtl/return_collector.sv
`default_nettype none
// ============================================================================
//  Module   : return_collector
//  Purpose  : Completion return path collector. Grants a tag (the ring tail
//             pointer) per issued request, accepts out-of-order completions by
//             tag into a DEPTH-entry ring and presents them strictly in issue
//             order on a valid/ready return port.
//  Ports    : clk  - clock, all logic on rising edge
//             rst  - synchronous active-high reset, discards every entry
//             rc   - return_collector_if.slave (alloc / cpl / ret / outstanding)
//  Revision : 1.0 - initial release
// ============================================================================
module return_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int TAG_WIDTH  = 6
) (
  input  wire logic           clk,
  input  wire logic           rst,
  return_collector_if.slave   rc
);

  localparam logic [TAG_WIDTH:0]   c_DEPTH_CNT = DEPTH[TAG_WIDTH:0];
  localparam logic [TAG_WIDTH-1:0] c_TAG_ONE   = {{(TAG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TAG_WIDTH:0]   c_CNT_ONE   = {{TAG_WIDTH{1'b0}}, 1'b1};

  // Ring pointers and occupancy
  logic [TAG_WIDTH-1:0]  r_head;
  logic [TAG_WIDTH-1:0]  r_tail;
  logic [TAG_WIDTH:0]    r_count;

  // Per-entry state
  logic [DEPTH-1:0]      r_alloc;
  logic [DEPTH-1:0]      r_done;
  logic [DEPTH-1:0]      r_is_read;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  logic                  r_cpl_error;

  logic                  w_alloc_ready;
  logic                  w_alloc_fire;
  logic                  w_cpl_ok;
  logic                  w_ret_valid;
  logic                  w_pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // does not open a slot until the following cycle.
  assign w_alloc_ready = (r_count != c_DEPTH_CNT);
  assign w_alloc_fire  = rc.alloc_valid & w_alloc_ready;

  // Acceptance looks at registered entry state: a tag being allocated this
  // cycle is not yet allocated, and the tag being popped is already done, so
  // both are rejected without any special-case logic.
  assign w_cpl_ok      = rc.cpl_valid & r_alloc[rc.cpl_tag] & ~r_done[rc.cpl_tag];

  assign w_ret_valid   = r_alloc[r_head] & r_done[r_head];
  assign w_pop         = w_ret_valid & rc.ret_ready;

  // Alloc, completion and pop never touch the same entry bit in one cycle:
  // the tail slot is always free when alloc fires, a completion needs an
  // allocated-not-done slot, and a pop needs a done slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_alloc     <= '0;
      r_done      <= '0;
      r_is_read   <= '0;
      r_cpl_error <= 1'b0;
    end else begin
      r_cpl_error <= rc.cpl_valid & ~w_cpl_ok;

      if (w_alloc_fire) begin
        r_alloc[r_tail]   <= 1'b1;
        r_done[r_tail]    <= 1'b0;
        r_is_read[r_tail] <= rc.alloc_is_read;
        r_tail            <= r_tail + c_TAG_ONE;
      end

      if (w_cpl_ok) begin
        r_done[rc.cpl_tag] <= 1'b1;
      end

      if (w_pop) begin
        r_alloc[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + c_TAG_ONE;
      end

      unique case ({w_alloc_fire, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data storage; contents are only observable through a valid read
  // entry, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_cpl_ok && r_is_read[rc.cpl_tag]) begin
      r_data[rc.cpl_tag] <= rc.cpl_data;
    end
  end

  assign rc.alloc_ready = w_alloc_ready;
  assign rc.alloc_tag   = r_tail;
  assign rc.cpl_error   = r_cpl_error;
  assign rc.ret_valid   = w_ret_valid;
  assign rc.ret_is_read = w_ret_valid & r_is_read[r_head];
  assign rc.ret_data    = (w_ret_valid && r_is_read[r_head]) ? r_data[r_head] : '0;
  assign rc.outstanding = r_count;

endmodule
`default_nettype wire

// File: tb/tb_return_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_return_collector
//  Purpose  : Self-checking bench for return_collector. Expected returns are
//             queued at allocation time; a monitor pops and compares every
//             return handshake and accounts for every cpl_error pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_return_collector;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } ret_t;

  logic clk;
  logic rst;

  return_collector_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) rc_bus ();

  return_collector #(.DATA_WIDTH(32), .DEPTH(64), .TAG_WIDTH(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .rc  (rc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests   = 0;
  int          fails   = 0;
  int          exp_err = 0;
  ret_t        sb[$];
  logic [5:0]  exp_tail;
  logic [31:0] tag_data   [64];
  logic        tag_isread [64];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rc_bus.alloc_valid = 1'b0;
    rc_bus.cpl_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    exp_tail = '0;
  endtask

  task automatic drive_alloc(input bit rd, input logic [31:0] d);
    ret_t e;
    chk("alloc_ready", 32'(rc_bus.alloc_ready), 32'd1);
    chk("alloc_tag", 32'(rc_bus.alloc_tag), 32'(exp_tail));
    rc_bus.alloc_valid   = 1'b1;
    rc_bus.alloc_is_read = rd;
    tag_isread[exp_tail] = rd;
    tag_data[exp_tail]   = d;
    e.is_read = rd;
    e.data    = rd ? d : 32'h0;
    sb.push_back(e);
    exp_tail++;
  endtask

  task automatic drive_cpl(input logic [5:0] tag, input bit expect_err);
    rc_bus.cpl_valid = 1'b1;
    rc_bus.cpl_tag   = tag;
    rc_bus.cpl_data  = (!expect_err && tag_isread[tag]) ? tag_data[tag] : $urandom;
    if (expect_err) exp_err++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      step();
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: drain timeout, %0d returns still expected, want 0", name, sb.size());
    end
  endtask

  // Monitor: scoreboard compare, hold-stability and error-pulse accounting
  initial begin
    bit          prev_stall = 1'b0;
    logic        prev_rd    = 1'b0;
    logic [31:0] prev_data  = '0;
    ret_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (!(rc_bus.ret_valid && rc_bus.ret_is_read == prev_rd && rc_bus.ret_data == prev_data)) begin
            fails++;
            $display("FAIL ret_hold: got v=%0b r=%0b d=%h expected v=1 r=%0b d=%h",
                     rc_bus.ret_valid, rc_bus.ret_is_read, rc_bus.ret_data, prev_rd, prev_data);
          end
        end
        if (rc_bus.ret_valid && rc_bus.ret_ready) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL ret_unexpected: got r=%0b d=%h expected no return",
                     rc_bus.ret_is_read, rc_bus.ret_data);
          end else begin
            e = sb.pop_front();
            if (rc_bus.ret_is_read !== e.is_read || rc_bus.ret_data !== e.data) begin
              fails++;
              $display("FAIL ret_order: got r=%0b d=%h expected r=%0b d=%h",
                       rc_bus.ret_is_read, rc_bus.ret_data, e.is_read, e.data);
            end
          end
        end
        if (rc_bus.cpl_error) begin
          tests++;
          if (exp_err > 0) begin
            exp_err--;
          end else begin
            fails++;
            $display("FAIL cpl_error: got unexpected pulse expected none");
          end
        end
        prev_stall = rc_bus.ret_valid && !rc_bus.ret_ready;
        prev_rd    = rc_bus.ret_is_read;
        prev_data  = rc_bus.ret_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pending[$];
    int         issued;
    int         idx;
    int         cyc;

    rst                  = 1'b1;
    rc_bus.alloc_valid   = 1'b0;
    rc_bus.alloc_is_read = 1'b0;
    rc_bus.cpl_valid     = 1'b0;
    rc_bus.cpl_tag       = '0;
    rc_bus.cpl_data      = '0;
    rc_bus.ret_ready     = 1'b0;
    exp_tail             = '0;
    for (int i = 0; i < 64; i++) begin
      tag_data[i]   = '0;
      tag_isread[i] = 1'b0;
    end
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_alloc_ready", 32'(rc_bus.alloc_ready), 32'd1);
    chk("rst_alloc_tag",   32'(rc_bus.alloc_tag),   32'd0);
    chk("rst_cpl_error",   32'(rc_bus.cpl_error),   32'd0);
    chk("rst_ret_valid",   32'(rc_bus.ret_valid),   32'd0);
    chk("rst_ret_is_read", 32'(rc_bus.ret_is_read), 32'd0);
    chk("rst_ret_data",    rc_bus.ret_data,         32'd0);
    chk("rst_outstanding", 32'(rc_bus.outstanding), 32'd0);

    // 1: out-of-order completion, in-order return
    drive_alloc(1'b0, 32'h0);        step();
    drive_alloc(1'b1, 32'hDEADBEEF); step();
    drive_alloc(1'b0, 32'h0);        step();
    chk("t1_outstanding3", 32'(rc_bus.outstanding), 32'd3);
    drive_cpl(6'd2, 1'b0); step();
    chk("t1_no_ret_a", 32'(rc_bus.ret_valid), 32'd0);
    drive_cpl(6'd1, 1'b0); step();
    chk("t1_no_ret_b", 32'(rc_bus.ret_valid), 32'd0);
    drive_cpl(6'd0, 1'b0); step();
    chk("t1_ret_valid", 32'(rc_bus.ret_valid), 32'd1);
    rc_bus.ret_ready = 1'b1;
    wait_drain("t1_drain");
    step();
    chk("t1_outstanding0", 32'(rc_bus.outstanding), 32'd0);
    rc_bus.ret_ready = 1'b0;

    // 2: fill all 64 entries, full back-pressure, free one slot
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive_alloc(1'(i), $urandom);
      step();
    end
    chk("t2_full_ready", 32'(rc_bus.alloc_ready), 32'd0);
    chk("t2_full_outstanding", 32'(rc_bus.outstanding), 32'd64);
    repeat (3) begin
      rc_bus.alloc_valid = 1'b1;
      step();
      chk("t2_hold_ready", 32'(rc_bus.alloc_ready), 32'd0);
      chk("t2_hold_outstanding", 32'(rc_bus.outstanding), 32'd64);
    end
    rc_bus.alloc_valid = 1'b1;
    drive_cpl(6'd0, 1'b0);
    step();
    rc_bus.alloc_valid = 1'b1;
    rc_bus.ret_ready   = 1'b1;
    chk("t2_pop_valid", 32'(rc_bus.ret_valid), 32'd1);
    chk("t2_pop_ready_still0", 32'(rc_bus.alloc_ready), 32'd0);
    step();
    rc_bus.ret_ready = 1'b0;
    drive_alloc(1'b1, 32'hCAFE0000);
    step();
    chk("t2_refill_outstanding", 32'(rc_bus.outstanding), 32'd64);
    for (int i = 1; i <= 64; i++) begin
      drive_cpl(6'(i), 1'b0);
      step();
    end
    rc_bus.ret_ready = 1'b1;
    wait_drain("t2_drain");
    step();
    chk("t2_outstanding0", 32'(rc_bus.outstanding), 32'd0);

    // 3: 200 requests, random completion order and random back-pressure
    do_reset();
    pending.delete();
    issued = 0;
    cyc    = 0;
    while (!(issued == 200 && pending.size() == 0 && sb.size() == 0) && cyc < 6000) begin
      rc_bus.ret_ready = 1'($urandom_range(0, 1));
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, pending.size() - 1);
        drive_cpl(pending[idx], 1'b0);
        pending.delete(idx);
      end
      if (issued < 200 && sb.size() < 60 && $urandom_range(0, 2) != 0) begin
        pending.push_back(exp_tail);
        drive_alloc(1'($urandom_range(0, 1)), $urandom);
        issued++;
      end
      step();
      cyc++;
    end
    chk("t3_issued", 32'(issued), 32'd200);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_outstanding0", 32'(rc_bus.outstanding), 32'd0);
    chk("t3_err_pending", 32'(exp_err), 32'd0);

    // 4: completion to unallocated tag, duplicate completion
    do_reset();
    rc_bus.ret_ready = 1'b0;
    drive_alloc(1'b0, 32'h0);        step();
    drive_alloc(1'b1, 32'h0BADF00D); step();
    drive_cpl(6'd5, 1'b1); step();
    drive_cpl(6'd0, 1'b0); step();
    drive_cpl(6'd0, 1'b1); step();
    step();
    step();
    chk("t4_err_seen", 32'(exp_err), 32'd0);
    chk("t4_outstanding", 32'(rc_bus.outstanding), 32'd2);
    chk("t4_ret_valid", 32'(rc_bus.ret_valid), 32'd1);
    chk("t4_ret_is_read", 32'(rc_bus.ret_is_read), 32'd0);
    drive_cpl(6'd1, 1'b0);
    rc_bus.ret_ready = 1'b1;
    wait_drain("t4_drain");
    step();
    chk("t4_outstanding0", 32'(rc_bus.outstanding), 32'd0);

    // 5: alloc, completion of next head and pop in one cycle
    do_reset();
    rc_bus.ret_ready = 1'b0;
    drive_alloc(1'b0, 32'h0);        step();
    drive_alloc(1'b1, 32'h55AA1234); step();
    drive_cpl(6'd0, 1'b0); step();
    step();
    rc_bus.ret_ready = 1'b1;
    drive_cpl(6'd1, 1'b0);
    drive_alloc(1'b0, 32'h0);
    chk("t5_before", 32'(rc_bus.outstanding), 32'd2);
    step();
    chk("t5_outstanding", 32'(rc_bus.outstanding), 32'd2);
    chk("t5_next_valid", 32'(rc_bus.ret_valid), 32'd1);
    chk("t5_next_is_read", 32'(rc_bus.ret_is_read), 32'd1);
    chk("t5_next_data", rc_bus.ret_data, 32'h55AA1234);
    step();
    drive_cpl(6'd2, 1'b0);
    wait_drain("t5_drain");
    step();
    chk("t5_outstanding0", 32'(rc_bus.outstanding), 32'd0);

    // 6: reset with 10 outstanding, 4 of them done
    do_reset();
    rc_bus.ret_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_alloc(1'(i), 32'h1000 + 32'(i));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive_cpl(6'(i), 1'b0);
      step();
    end
    chk("t6_pre_outstanding", 32'(rc_bus.outstanding), 32'd10);
    chk("t6_pre_valid", 32'(rc_bus.ret_valid), 32'd1);
    do_reset();
    chk("t6_ret_valid", 32'(rc_bus.ret_valid), 32'd0);
    chk("t6_outstanding", 32'(rc_bus.outstanding), 32'd0);
    chk("t6_alloc_tag", 32'(rc_bus.alloc_tag), 32'd0);
    chk("t6_alloc_ready", 32'(rc_bus.alloc_ready), 32'd1);
    drive_cpl(6'd0, 1'b1); step();
    drive_cpl(6'd5, 1'b1); step();
    step();
    step();
    chk("t6_err_seen", 32'(exp_err), 32'd0);
    chk("t6_still_idle", 32'(rc_bus.ret_valid), 32'd0);
    chk("t6_outstanding_end", 32'(rc_bus.outstanding), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
